// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe: load-use bubbles, branch
// squash, data-memory wait freeze, stall counter and memory-timeout fault.
module pipeline_hazard_ctrl #(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             IDEX_MemRead,
  input  logic [4:0]       IDEX_WriteReg,
  input  logic [4:0]       IFID_Rs,
  input  logic [4:0]       IFID_Rt,
  input  logic             IFID_UsesRt,
  input  logic             BranchTaken,
  input  logic             MemReq,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Write,
  output logic             IDEX_Flush,
  output logic             EXMEM_Write,
  output logic             MEMWB_Bubble,
  output logic [CNT_W-1:0] StallCount,
  output logic             Fault
);

  localparam int unsigned WW = $clog2(MAX_WAIT + 1);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_FLT  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;

  logic load_use;
  logic wr_rs;
  logic wr_rt;
  logic freeze;

  assign wr_rs = (IDEX_WriteReg == IFID_Rs);
  assign wr_rt = IFID_UsesRt & (IDEX_WriteReg == IFID_Rt);

  assign load_use = IDEX_MemRead
                  & (IDEX_WriteReg != 5'd0)
                  & (wr_rs | wr_rt);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    fault_d = fault_q;
    freeze  = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (MemReq && !MemReady) begin
          freeze  = 1'b1;
          state_d = S_WAIT;
          wait_d  = WW'(1);
        end
      end
      S_WAIT: begin
        if (MemReady) begin
          state_d = S_RUN;
          wait_d  = '0;
        end else if (wait_q == WW'(MAX_WAIT)) begin
          freeze  = 1'b1;
          state_d = S_FLT;
          fault_d = 1'b1;
        end else begin
          freeze  = 1'b1;
          wait_d  = wait_q + 1'b1;
        end
      end
      S_FLT: begin
        freeze  = 1'b1;
        fault_d = 1'b1;
      end
      default: begin
        freeze  = 1'b1;
        state_d = S_RUN;
        wait_d  = '0;
      end
    endcase
  end

  // A taken branch squashes the hazard instruction, so it beats load-use.
  always_comb begin
    PCWrite      = 1'b1;
    IFID_Write   = 1'b1;
    IFID_Flush   = 1'b0;
    IDEX_Write   = 1'b1;
    IDEX_Flush   = 1'b0;
    EXMEM_Write  = 1'b1;
    MEMWB_Bubble = 1'b0;
    priority case (1'b1)
      freeze: begin
        PCWrite      = 1'b0;
        IFID_Write   = 1'b0;
        IDEX_Write   = 1'b0;
        EXMEM_Write  = 1'b0;
        MEMWB_Bubble = 1'b1;
      end
      BranchTaken: begin
        IFID_Flush = 1'b1;
        IDEX_Flush = 1'b1;
      end
      load_use: begin
        PCWrite    = 1'b0;
        IFID_Write = 1'b0;
        IDEX_Flush = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!PCWrite && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_RUN;
      wait_q  <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  assign StallCount = cnt_q;
  assign Fault      = fault_q;

endmodule
